// File: rtl/ysyx_22050133_axi_master_arb_if.sv
// AXI4 master-port bundle between the core arbiter and the simulation AXI slave.
// Signal names keep the bus-side _o/_i suffixes seen from the arbiter.
interface ysyx_22050133_axi_master_arb_if #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                          axi_aw_valid_o;
    logic [AXI_ID_WIDTH-1:0]       axi_aw_id_o;
    logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_o;
    logic [7:0]                    axi_aw_len_o;
    logic [2:0]                    axi_aw_size_o;
    logic [1:0]                    axi_aw_burst_o;
    logic                          axi_aw_ready_i;

    logic                          axi_w_valid_o;
    logic [AXI_DATA_WIDTH-1:0]     axi_w_data_o;
    logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_o;
    logic                          axi_w_last_o;
    logic                          axi_w_ready_i;

    logic                          axi_b_ready_o;
    logic                          axi_b_valid_i;
    logic [AXI_ID_WIDTH-1:0]       axi_b_id_i;
    logic [1:0]                    axi_b_resp_i;

    logic                          axi_ar_valid_o;
    logic [AXI_ID_WIDTH-1:0]       axi_ar_id_o;
    logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_o;
    logic [7:0]                    axi_ar_len_o;
    logic [2:0]                    axi_ar_size_o;
    logic [1:0]                    axi_ar_burst_o;
    logic                          axi_ar_ready_i;

    logic                          axi_r_ready_o;
    logic                          axi_r_valid_i;
    logic [AXI_ID_WIDTH-1:0]       axi_r_id_i;
    logic [1:0]                    axi_r_resp_i;
    logic [AXI_DATA_WIDTH-1:0]     axi_r_data_i;
    logic                          axi_r_last_i;

    modport master (
        output axi_aw_valid_o, axi_aw_id_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
        input  axi_aw_ready_i,
        output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        input  axi_w_ready_i,
        output axi_b_ready_o,
        input  axi_b_valid_i, axi_b_id_i, axi_b_resp_i,
        output axi_ar_valid_o, axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
        input  axi_ar_ready_i,
        output axi_r_ready_o,
        input  axi_r_valid_i, axi_r_id_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i
    );

    modport slave (
        input  axi_aw_valid_o, axi_aw_id_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
        output axi_aw_ready_i,
        input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        output axi_w_ready_i,
        input  axi_b_ready_o,
        output axi_b_valid_i, axi_b_id_i, axi_b_resp_i,
        input  axi_ar_valid_o, axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
        output axi_ar_ready_i,
        input  axi_r_ready_o,
        output axi_r_valid_i, axi_r_id_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i
    );
endinterface

// File: rtl/ysyx_22050133_axi_master_arb.sv
// IF/MEM arbiter issuing one AXI4 INCR transaction at a time on a 64-bit master port.
// Define AXI_ARB_RR_EN for round-robin tie-breaking instead of fixed MEM-over-IF priority.
module ysyx_22050133_axi_master_arb #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        if_req_valid,
    output logic                        if_req_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   if_addr,
    input  logic [7:0]                  if_len,
    output logic                        if_rdata_valid,
    output logic [AXI_DATA_WIDTH-1:0]   if_rdata,
    output logic                        if_rlast,
    input  logic                        mem_req_valid,
    output logic                        mem_req_ready,
    input  logic                        mem_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr,
    input  logic [7:0]                  mem_len,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                        mem_wnext,
    output logic                        mem_rdata_valid,
    output logic [AXI_DATA_WIDTH-1:0]   mem_rdata,
    output logic                        mem_rlast,
    output logic                        mem_wdone,
    output logic                        err,
    output logic [2:0]                  dbg_state,
    ysyx_22050133_axi_master_arb_if.master axi
);
    // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
    // valid and its payload stay stable until that cycle, ready may toggle freely.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_AR = 3'd1, S_R = 3'd2, S_AW = 3'd3, S_W = 3'd4, S_B = 3'd5
    } state_t;

    localparam logic [AXI_ID_WIDTH-1:0] ID_IF  = AXI_ID_WIDTH'(1);
    localparam logic [AXI_ID_WIDTH-1:0] ID_MEM = AXI_ID_WIDTH'(0);

    state_t                    state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q, cnt_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      owner_mem_q;
    logic                      mem_wins_tie, grant_mem, grant_if, last_beat, beat;

`ifdef AXI_ARB_RR_EN
    logic last_mem_q;  // 0 = IF was granted last, so MEM takes the first tie
    assign mem_wins_tie = !last_mem_q;

    always_ff @(posedge clk) begin
        if (!rst)           last_mem_q <= 1'b0;
        else if (grant_mem) last_mem_q <= 1'b1;
        else if (grant_if)  last_mem_q <= 1'b0;
    end
`else
    assign mem_wins_tie = 1'b1;
`endif

    assign grant_mem = rst && (state == S_IDLE) && mem_req_valid && (!if_req_valid || mem_wins_tie);
    assign grant_if  = rst && (state == S_IDLE) && if_req_valid && !grant_mem;
    assign last_beat = (cnt_q == len_q);
    assign beat      = rst && (((state == S_R) && axi.axi_r_valid_i) || ((state == S_W) && axi.axi_w_ready_i));
    assign dbg_state = state;

    assign axi.axi_ar_id_o    = id_q;
    assign axi.axi_ar_addr_o  = addr_q;
    assign axi.axi_ar_len_o   = len_q;
    assign axi.axi_ar_size_o  = 3'd3;
    assign axi.axi_ar_burst_o = 2'b01;
    assign axi.axi_aw_id_o    = id_q;
    assign axi.axi_aw_addr_o  = addr_q;
    assign axi.axi_aw_len_o   = len_q;
    assign axi.axi_aw_size_o  = 3'd3;
    assign axi.axi_aw_burst_o = 2'b01;

    // Termination is counted locally, so the slave's id and last flags are not consumed.
    logic unused_ok;
    assign unused_ok = ^{axi.axi_b_id_i, axi.axi_r_id_i, axi.axi_r_last_i};

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (grant_mem)     state_nxt = mem_we ? S_AW : S_AR;
                    else if (grant_if) state_nxt = S_AR;
            S_AR:   if (axi.axi_ar_ready_i)           state_nxt = S_R;
            S_R:    if (axi.axi_r_valid_i && last_beat) state_nxt = S_IDLE;
            S_AW:   if (axi.axi_aw_ready_i)           state_nxt = S_W;
            S_W:    if (axi.axi_w_ready_i && last_beat) state_nxt = S_B;
            S_B:    if (axi.axi_b_valid_i)            state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        if_req_ready       = 1'b0;
        mem_req_ready      = 1'b0;
        if_rdata_valid     = 1'b0;
        if_rdata           = '0;
        if_rlast           = 1'b0;
        mem_rdata_valid    = 1'b0;
        mem_rdata          = '0;
        mem_rlast          = 1'b0;
        mem_wnext          = 1'b0;
        mem_wdone          = 1'b0;
        err                = 1'b0;
        axi.axi_ar_valid_o = 1'b0;
        axi.axi_aw_valid_o = 1'b0;
        axi.axi_w_valid_o  = 1'b0;
        axi.axi_w_data_o   = '0;
        axi.axi_w_strb_o   = '0;
        axi.axi_w_last_o   = 1'b0;
        axi.axi_b_ready_o  = 1'b0;
        axi.axi_r_ready_o  = 1'b0;
        // Reset masks everything at once so an in-flight beat is never forwarded.
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if_req_ready  = grant_if;
                    mem_req_ready = grant_mem;
                end
                S_AR: axi.axi_ar_valid_o = 1'b1;
                S_R: begin
                    axi.axi_r_ready_o = 1'b1;
                    if (axi.axi_r_valid_i) begin
                        err = (axi.axi_r_resp_i != 2'b00);
                        if (owner_mem_q) begin
                            mem_rdata_valid = 1'b1;
                            mem_rdata       = axi.axi_r_data_i;
                            mem_rlast       = last_beat;
                        end else begin
                            if_rdata_valid = 1'b1;
                            if_rdata       = axi.axi_r_data_i;
                            if_rlast       = last_beat;
                        end
                    end
                end
                S_AW: axi.axi_aw_valid_o = 1'b1;
                S_W: begin
                    axi.axi_w_valid_o = 1'b1;
                    axi.axi_w_data_o  = mem_wdata;
                    axi.axi_w_strb_o  = mem_wstrb;
                    axi.axi_w_last_o  = last_beat;
                    mem_wnext         = axi.axi_w_ready_i;
                end
                S_B: begin
                    axi.axi_b_ready_o = 1'b1;
                    if (axi.axi_b_valid_i) begin
                        mem_wdone = 1'b1;
                        err       = (axi.axi_b_resp_i != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            owner_mem_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (grant_mem) begin
                addr_q      <= mem_addr;
                len_q       <= mem_len;
                id_q        <= ID_MEM;
                owner_mem_q <= 1'b1;
            end else if (grant_if) begin
                addr_q      <= if_addr;
                len_q       <= if_len;
                id_q        <= ID_IF;
                owner_mem_q <= 1'b0;
            end
            if (beat) cnt_q <= last_beat ? 8'd0 : cnt_q + 8'd1;
        end
    end
endmodule

// File: doc/ysyx_22050133_axi_master_arb.md
Name: ysyx_22050133_axi_master_arb

Overview:
Upstream AXI master for the core's memory path. It arbitrates between the instruction-fetch read port (IF) and the data port (MEM, read or write) and issues one AXI4 transaction at a time on a single 64-bit master port. That port drives the simulation AXI slave. Read beats are forwarded to the owning requester; write beats are pulled from MEM one at a time.

Parameters:
AXI_DATA_WIDTH, 64, data bus width (only 64 supported)
AXI_ADDR_WIDTH, 32, address width
AXI_ID_WIDTH, 4, ID width; IF uses ID 1, MEM uses ID 0

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-low reset (reset when rst==0)
if_req_valid  input  1  IF read request pending
if_req_ready  output  1  IF request accepted this cycle
if_addr  input  32  IF burst start address
if_len  input  8  IF beats minus 1
if_rdata_valid  output  1  IF read beat valid
if_rdata  output  64  IF read beat data
if_rlast  output  1  final IF beat
mem_req_valid  input  1  MEM request pending
mem_req_ready  output  1  MEM request accepted this cycle
mem_we  input  1  1 = write, 0 = read
mem_addr  input  32  MEM burst start address
mem_len  input  8  MEM beats minus 1
mem_wdata  input  64  current write beat data
mem_wstrb  input  8  current write beat strobes
mem_wnext  output  1  current write beat consumed; present the next one
mem_rdata_valid / mem_rdata / mem_rlast  output  1/64/1  same as the IF equivalents
mem_wdone  output  1  write response received
err  output  1  one-cycle pulse when resp is non-zero (r or b)
axi_aw_{valid,id,addr,len,size,burst}_o  output  1/4/32/8/3/2  AW channel
axi_aw_ready_i  input  1
axi_w_{valid,data,strb,last}_o  output  1/64/8/1  W channel
axi_w_ready_i  input  1
axi_b_ready_o  output  1
axi_b_{valid,id,resp}_i  input  1/4/2
axi_ar_{valid,id,addr,len,size,burst}_o  output  1/4/32/8/3/2  AR channel
axi_ar_ready_i  input  1
axi_r_ready_o  output  1
axi_r_{valid,id,resp,data,last}_i  input  1/4/2/64/1

Behaviour:
- Reset: state IDLE, beat counter 0. All valid, ready and pulse outputs are 0. Address, len, id and data outputs are 0.
- Transactions: one outstanding only; no read during a write and vice versa. size is fixed at 3'd3 (8 bytes) and burst at 2'b01 (INCR).
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE arbitration:
  - Grant goes to a requester with req_valid=1. Default priority is MEM over IF.
  - req_ready is combinational and high only in IDLE, only for the granted requester.
  - On grant, latch addr, len, we and owner id. Go to AR (read) or AW (write). AR/AW valid rises the next cycle.
  - Requester inputs other than wdata/wstrb are don't-care after the grant.
- AR: ar_valid=1 with latched fields, held stable until ar_ready; then go to R.
- R:
  - r_ready=1.
  - Each r_valid&r_ready beat drives the owner's rdata_valid=1 and rdata=r_data combinationally in the same cycle.
  - The beat counter increments per beat.
  - The burst ends on the beat where counter==len. That beat asserts the owner's rlast, resets the counter and returns to IDLE.
  - axi_r_last_i and r_id are ignored for termination; the slave is not required to drive last.
- AW: aw_valid=1 until aw_ready; then go to W. W never starts before the AW handshake.
- W:
  - w_valid=1 with w_data=mem_wdata and w_strb=mem_wstrb, passed through.
  - w_last=1 when counter==len.
  - Each w_valid&w_ready beat pulses mem_wnext and increments the counter. After the last beat, go to B.
  - MEM must hold wdata/wstrb stable until mem_wnext.
- B: b_ready=1. On b_valid, pulse mem_wdone for one cycle and return to IDLE.
- err: pulses one cycle on any accepted R beat or B response with resp!=2'b00. The transaction still completes normally.
- len=0: single beat; rlast/w_last are set on the first beat.
- Reset mid-transaction: returns to IDLE immediately and drops all valids. No completion or rlast pulses are generated.
- Back-to-back: after returning to IDLE, a new grant is possible in that same IDLE cycle, so there is a minimum of one idle cycle between transactions.

Optional Feature:
Macro: AXI_ARB_RR_EN
- Defined: round-robin arbitration. When both requesters are pending, the one not granted last wins. The last-grant register resets to IF, so MEM wins the first tie.
- Undefined: fixed MEM-over-IF priority.

Test Plan:
- IF read, addr 0x80000000, len 0, ar_ready after 2 cycles -> ar_id=1, ar_len=0, ar_size=3, ar_burst=1. One if_rdata_valid with if_rlast=1 and data equal to r_data; FSM back in IDLE.
- MEM read, addr 0x80001000, len 3, r_valid gaps of 1 cycle, axi_r_last_i held 0 -> 4 mem_rdata_valid beats, mem_rlast only on the 4th. if_rdata_valid is never asserted.
- IF and MEM requests in the same cycle -> MEM granted first, IF granted on the next IDLE. With AXI_ARB_RR_EN and both held pending, grants alternate MEM, IF, MEM.
- MEM write, len 1, data 0x1122334455667788 then 0x99AABBCCDDEEFF00, strb 0xFF, w_ready delayed 2 cycles -> two mem_wnext pulses, w_last only on beat 2, mem_wdone after b_valid.
- b_resp=2'b10 on a write, and r_resp=2'b10 on a read beat -> err pulses exactly one cycle each; both transactions complete.
- rst driven to 0 during R of a len=7 read after 3 beats -> next cycle all valids and readies are 0, no rlast pulse; a new IF request is granted after rst returns to 1.
